instr_encoder: RTL

//  Streaming assembler/loader for the 9-bit ISA: converts (mnemonic, register address, immediate) tuples into packed 9-bit instruction words.
//  It range-checks every operand against the register windows the ISA field widths allow.

---
 rtl/instr_encoder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: streaming assembler/loader for the 9-bit ISA.
// Turns (mnemonic, register, immediate) tuples into packed instruction words,
// range-checks every operand against its ISA register window and writes each
// good word to instruction memory at consecutive addresses.
module instr_encoder #(
    parameter int INSTR_W    = 9,
    parameter int RADDR_W    = 4,
    parameter int IMM_W      = 6,
    parameter int IMEM_DEPTH = 256,
    localparam int ADDR_W    = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         mnem,
    input  logic [RADDR_W-1:0] rd,
    input  logic [RADDR_W-1:0] rs,
    input  logic [RADDR_W-1:0] rt,
    input  logic [IMM_W-1:0]   imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic [ADDR_W:0]    word_count,
    output logic               load_done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [ADDR_W-1:0]  err_addr
);

    localparam logic [4:0] M_AND  = 5'd0;
    localparam logic [4:0] M_SLT  = 5'd1;
    localparam logic [4:0] M_OR   = 5'd2;
    localparam logic [4:0] M_BEQ  = 5'd3;
    localparam logic [4:0] M_LW   = 5'd4;
    localparam logic [4:0] M_SW   = 5'd5;
    localparam logic [4:0] M_INC  = 5'd6;
    localparam logic [4:0] M_NOT  = 5'd7;
    localparam logic [4:0] M_ADD  = 5'd8;
    localparam logic [4:0] M_ADDI = 5'd9;
    localparam logic [4:0] M_SUB  = 5'd10;
    localparam logic [4:0] M_TR   = 5'd11;
    localparam logic [4:0] M_JR   = 5'd12;
    localparam logic [4:0] M_SRL  = 5'd13;
    localparam logic [4:0] M_SRA  = 5'd14;
    localparam logic [4:0] M_SLL  = 5'd15;
    localparam logic [4:0] M_DONE = 5'd16;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    localparam logic [ADDR_W:0] COUNT_LIMIT = (ADDR_W+1)'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISHED,
        ERROR
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] wr_ptr;
    logic [8:0]        enc;
    logic              range_ok;
    logic              illegal;
    logic              overflow;
    logic [1:0]        fault;
    logic              accept;
    logic [2:0]        tr_rd;
    logic [2:0]        tr_rs;

    // True when a register address lies inside the inclusive window lo..hi.
    function automatic logic in_win(input logic [RADDR_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    // TR windows start at 1 and 5, so subtract the base modulo 8 on the low bits.
    assign tr_rd = rd[2:0] - 3'd1;
    assign tr_rs = rs[2:0] - 3'd5;

    // A tuple taken in the same cycle as start is dropped in favour of the restart.
    assign accept   = in_valid && (state == LOAD) && !start;
    assign overflow = (word_count == COUNT_LIMIT);

    // Decode the mnemonic into a packed word and check each used operand window;
    // windows are 4-aligned so "operand minus base" is simply the low bits.
    always_comb begin
        enc      = '0;
        range_ok = 1'b1;
        illegal  = 1'b0;
        case (mnem)
            M_AND, M_SLT, M_OR: begin
                enc      = {3'b000, rs[1:0], rt[1:0], mnem[1:0]};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3);
            end
            M_BEQ: begin
                enc      = {3'b000, rs[1:0], rt[1:0], 2'b11};
                range_ok = in_win(rs, 0, 3) && in_win(rt, 8, 11);
            end
            M_LW: begin
                enc      = {3'b001, rs[1:0], rd[1:0], 2'b00};
                range_ok = in_win(rs, 4, 7) && in_win(rd, 0, 3);
            end
            M_SW: begin
                enc      = {3'b001, rs[1:0], rt[1:0], 2'b01};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3);
            end
            M_INC: begin
                enc      = {3'b001, rd[3:0], 2'b10};
                range_ok = in_win(rd, 0, 11);
            end
            M_NOT: begin
                enc      = {3'b001, rd[3:0], 2'b11};
                range_ok = in_win(rd, 0, 11);
            end
            M_ADD: begin
                enc      = {3'b010, rs[1:0], rt[1:0], rd[1:0]};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3) && in_win(rd, 8, 11);
            end
            M_SUB: begin
                enc      = {3'b100, rs[1:0], rt[1:0], rd[1:0]};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3) && in_win(rd, 8, 11);
            end
            M_ADDI: begin
                enc      = {3'b011, rd[1:0], rs[1:0], imm[1:0]};
                range_ok = in_win(rd, 8, 11) && in_win(rs, 0, 3) && (imm <= IMM_W'(3));
            end
            M_TR: begin
                enc      = {3'b101, tr_rd, tr_rs};
                range_ok = in_win(rd, 1, 8) && in_win(rs, 5, 12);
            end
            M_JR: begin
                enc      = {3'b110, imm[5:0]};
            end
            M_SRL: begin
                enc      = {3'b111, rs[1:0], rt[1:0], 2'b00};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3);
            end
            M_SRA: begin
                enc      = {3'b111, rs[1:0], rt[1:0], 2'b01};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3);
            end
            M_SLL: begin
                enc      = {3'b111, rs[1:0], rt[1:0], 2'b10};
                range_ok = in_win(rs, 4, 7) && in_win(rt, 0, 3);
            end
            M_DONE: begin
                enc      = 9'b111_0000_11;
            end
            default: begin
                illegal  = 1'b1;
            end
        endcase
    end

    // Pick the single reported fault: illegal beats range beats overflow.
    always_comb begin
        fault = ERR_NONE;
        if (illegal) begin
            fault = ERR_ILLEGAL;
        end else if (!range_ok) begin
            fault = ERR_RANGE;
        end else if (overflow) begin
            fault = ERR_OVERFLOW;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start always (re)enters LOAD from any state.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = LOAD;
        end else if (state == LOAD && accept) begin
            if (fault != ERR_NONE) begin
                next_state = ERROR;
            end else if (mnem == M_DONE) begin
                next_state = FINISHED;
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        in_ready  = (state == LOAD);
        load_done = (state == FINISHED);
        error     = (state == ERROR);
    end

    // Write pipeline, pointer, counter and error capture; a good accept writes next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            wr_ptr     <= '0;
            word_count <= '0;
            err_code   <= ERR_NONE;
            err_addr   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                wr_ptr     <= base_addr;
                word_count <= '0;
                err_code   <= ERR_NONE;
                err_addr   <= '0;
            end else if (accept) begin
                if (fault != ERR_NONE) begin
                    err_code <= fault;
                    err_addr <= wr_ptr;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= wr_ptr;
                    imem_wdata <= INSTR_W'(enc);
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    word_count <= word_count + (ADDR_W+1)'(1);
                end
            end
        end
    end

endmodule
